// File: rtl/jtdsp16_loop_cache_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jtdsp16_pkg
//  Description : Shared definitions for the DSP16 loop cache. Holds the
//                loop sequencer state encodings and the default widths and
//                depth used by the cache, its interface and its memory.
//  Revision    : 1.0  initial release
// ============================================================================
package jtdsp16_pkg;

   // Loop sequencer states
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_LOAD   = 2'd1;
   localparam logic [1:0] ST_REPLAY = 2'd2;

   // Default geometry
   localparam int DEFAULT_DW    = 16;  // instruction word width
   localparam int DEFAULT_DEPTH = 15;  // maximum loop body length
   localparam int DEFAULT_NIW   = 4;   // ni field / pointer width
   localparam int DEFAULT_KW    = 7;   // repeat count width

endpackage
`default_nettype wire

// File: rtl/jtdsp16_loop_cache_if.sv
`default_nettype none
// ============================================================================
//  Module      : jtdsp16_loop_cache_if
//  Description : Bus between the control unit and the loop cache.
//                master : core side (drives commands and ROM data)
//                slave  : loop cache side (drives instr and status)
//  Signals     : step, do_start, redo_start, ni, k, abort, rom_dout  (to cache)
//                instr, pc_halt, busy, bad_cmd, done                  (from cache)
//  Revision    : 1.0  initial release
// ============================================================================
interface jtdsp16_loop_cache_if
   import jtdsp16_pkg::*;
#(
   parameter int DW  = DEFAULT_DW,
   parameter int NIW = DEFAULT_NIW,
   parameter int KW  = DEFAULT_KW
);
   logic           step;
   logic           do_start;
   logic           redo_start;
   logic [NIW-1:0] ni;
   logic [KW-1:0]  k;
   logic           abort;
   logic [DW-1:0]  rom_dout;
   logic [DW-1:0]  instr;
   logic           pc_halt;
   logic           busy;
   logic           bad_cmd;
   logic           done;

   modport master (
      output step, do_start, redo_start, ni, k, abort, rom_dout,
      input  instr, pc_halt, busy, bad_cmd, done
   );

   modport slave (
      input  step, do_start, redo_start, ni, k, abort, rom_dout,
      output instr, pc_halt, busy, bad_cmd, done
   );
endinterface
`default_nettype wire

// File: rtl/jtdsp16_cache_mem.sv
`default_nettype none
// ============================================================================
//  Module      : jtdsp16_cache_mem
//  Description : DEPTH x DW register file holding the loop body.
//                Synchronous write, asynchronous read. Not cleared by reset.
//  Ports       : clk   - clock
//                we    - write enable
//                waddr - write address
//                din   - write data
//                raddr - read address
//                dout  - read data (combinational)
//  Revision    : 1.0  initial release
// ============================================================================
module jtdsp16_cache_mem #(
   parameter int DW    = 16,
   parameter int DEPTH = 15,
   parameter int AW    = 4
)(
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] din,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] dout
);
   logic [DW-1:0] mem [0:DEPTH-1];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= din;
   end

   assign dout = mem[raddr];
endmodule
`default_nettype wire

// File: rtl/jtdsp16_loop_cache.sv
`default_nettype none
// ============================================================================
//  Module      : jtdsp16_loop_cache
//  Description : Instruction cache and loop sequencer for DSP16 "do K {NI}"
//                and "redo K". The body is captured from ROM on the first
//                pass and replayed K-1 times while the ROM PC is halted.
//  Ports       : clk, rst (sync, active high), cen (clock enable)
//                bus : jtdsp16_loop_cache_if.slave
//                      step/do_start/redo_start/ni/k/abort/rom_dout in,
//                      instr/pc_halt/busy/bad_cmd/done out
//  Options     : JTDSP16_LOOP_ABORT_EN - enables the abort input. When not
//                defined the abort signal is ignored.
//  Revision    : 1.0  initial release
// ============================================================================
module jtdsp16_loop_cache
   import jtdsp16_pkg::*;
#(
   parameter int DW    = DEFAULT_DW,
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int NIW   = DEFAULT_NIW,
   parameter int KW    = DEFAULT_KW
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cen,
   jtdsp16_loop_cache_if.slave  bus
);
   localparam logic [NIW:0]  DEPTH_W = (NIW+1)'(DEPTH);
   localparam logic [KW-1:0] K_ONE   = KW'(1);

   logic [1:0]     state;
   logic [NIW-1:0] stored_ni;
   logic [KW-1:0]  stored_k;
   logic [NIW-1:0] wr_ptr;
   logic [NIW-1:0] rd_ptr;
   logic [KW-1:0]  remaining;
   logic           valid;

   logic [NIW-1:0] last_idx;
   logic [DW-1:0]  mem_dout;
   logic           adv;
   logic           do_ok;
   logic           redo_ok;
   logic           accept_do;
   logic           accept_redo;
   logic           reject;
   logic           load_last;
   logic           replay_last;
   logic           abort_load;
   logic           abort_replay;
   logic           mem_we;

   assign adv      = cen & bus.step;
   assign last_idx = stored_ni - 1'b1;

   // Command validation
   assign do_ok   = (bus.ni != '0) && ({1'b0, bus.ni} <= DEPTH_W) && (bus.k != '0);
   assign redo_ok = valid && (bus.k != '0);

   // do has priority over redo; anything outside IDLE is a nesting attempt
   assign accept_do   = cen && (state == ST_IDLE) && bus.do_start && do_ok;
   assign accept_redo = cen && (state == ST_IDLE) && !bus.do_start &&
                        bus.redo_start && redo_ok;
   assign reject      = cen && (bus.do_start || bus.redo_start) &&
                        !(accept_do || accept_redo);

   assign load_last   = adv && (state == ST_LOAD) && (wr_ptr == last_idx);
   assign replay_last = adv && (state == ST_REPLAY) && (rd_ptr == last_idx) &&
                        (remaining == K_ONE);

`ifdef JTDSP16_LOOP_ABORT_EN
   assign abort_load   = cen && bus.abort && (state == ST_LOAD);
   assign abort_replay = cen && bus.abort && (state == ST_REPLAY);
`else
   logic unused_abort;
   assign unused_abort = bus.abort;
   assign abort_load   = 1'b0;
   assign abort_replay = 1'b0;
`endif

   // A truncated body is never written past the abort point
   assign mem_we = adv && (state == ST_LOAD) && !abort_load;

   jtdsp16_cache_mem #(
      .DW    (DW),
      .DEPTH (DEPTH),
      .AW    (NIW)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (wr_ptr),
      .din   (bus.rom_dout),
      .raddr (rd_ptr),
      .dout  (mem_dout)
   );

   // Pulses are combinational so they line up with the instruction that
   // causes them (done marks the last body word while it is on instr).
   assign bus.bad_cmd = reject || abort_load;
   assign bus.done    = (load_last && (stored_k == K_ONE) && !abort_load) ||
                        replay_last || abort_replay;
   assign bus.pc_halt = (state == ST_REPLAY);
   assign bus.busy    = (state != ST_IDLE);
   assign bus.instr   = (state == ST_REPLAY) ? mem_dout : bus.rom_dout;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         valid     <= 1'b0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         remaining <= '0;
         stored_ni <= '0;
         stored_k  <= '0;
      end else if (cen) begin
         case (state)
            ST_IDLE: begin
               if (accept_do) begin
                  stored_ni <= bus.ni;
                  stored_k  <= bus.k;
                  wr_ptr    <= '0;
                  valid     <= 1'b0;
                  state     <= ST_LOAD;
               end else if (accept_redo) begin
                  stored_k  <= bus.k;
                  rd_ptr    <= '0;
                  remaining <= bus.k;
                  state     <= ST_REPLAY;
               end
            end
            ST_LOAD: begin
               if (abort_load) begin
                  valid <= 1'b0;
                  state <= ST_IDLE;
               end else if (bus.step) begin
                  wr_ptr <= wr_ptr + 1'b1;
                  if (wr_ptr == last_idx) begin
                     valid <= 1'b1;
                     if (stored_k == K_ONE) begin
                        state <= ST_IDLE;
                     end else begin
                        rd_ptr    <= '0;
                        remaining <= stored_k - 1'b1;
                        state     <= ST_REPLAY;
                     end
                  end
               end
            end
            ST_REPLAY: begin
               if (abort_replay) begin
                  state <= ST_IDLE;
               end else if (bus.step) begin
                  if (rd_ptr == last_idx) begin
                     rd_ptr    <= '0;
                     remaining <= remaining - 1'b1;
                     if (remaining == K_ONE) state <= ST_IDLE;
                  end else begin
                     rd_ptr <= rd_ptr + 1'b1;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_jtdsp16_loop_cache.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jtdsp16_loop_cache
//  Description : Directed self-checking bench for jtdsp16_loop_cache.
//                Define JTDSP16_LOOP_ABORT_EN to include the abort sequence.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_jtdsp16_loop_cache;
   logic clk;
   logic rst;
   logic cen;
   int   pass_cnt;
   int   total_cnt;
   int   halt_cnt;

   logic [15:0] body3 [0:2];
   logic [15:0] body2 [0:1];

   jtdsp16_loop_cache_if #(.DW(16), .NIW(4), .KW(7)) bus ();

   jtdsp16_loop_cache #(.DW(16), .DEPTH(15), .NIW(4), .KW(7)) dut (
      .clk (clk),
      .rst (rst),
      .cen (cen),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Advance one clock edge; inputs change 1ns after it, checks happen 2ns later
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic idle_in();
      bus.step       = 1'b0;
      bus.do_start   = 1'b0;
      bus.redo_start = 1'b0;
      bus.abort      = 1'b0;
   endtask

   initial begin
      pass_cnt  = 0;
      total_cnt = 0;
      body3[0] = 16'hA00A; body3[1] = 16'hB00B; body3[2] = 16'hC00C;
      body2[0] = 16'h1111; body2[1] = 16'h2222;
      rst = 1'b1;
      cen = 1'b1;
      idle_in();
      bus.ni = '0;
      bus.k  = '0;
      bus.rom_dout = 16'h1234;
      tick(); tick();
      settle();
      // ---------------- reset state
      chk("rst_busy",    32'(bus.busy),    0);
      chk("rst_pc_halt", 32'(bus.pc_halt), 0);
      chk("rst_done",    32'(bus.done),    0);
      chk("rst_bad_cmd", 32'(bus.bad_cmd), 0);
      chk("rst_instr",   32'(bus.instr),   32'h1234);
      tick();
      rst = 1'b0;

      // ---------------- redo before any do
      bus.redo_start = 1'b1; bus.k = 7'd2; bus.step = 1'b1;
      settle();
      chk("redo_nodo_bad", 32'(bus.bad_cmd), 1);
      tick(); idle_in(); settle();
      chk("redo_nodo_busy", 32'(bus.busy), 0);

      // ---------------- illegal do: ni=0 (ni=DEPTH+1 does not fit in NIW bits)
      tick();
      bus.do_start = 1'b1; bus.ni = 4'd0; bus.k = 7'd3;
      settle();
      chk("do_ni0_bad", 32'(bus.bad_cmd), 1);
      tick(); idle_in(); settle();
      chk("do_ni0_busy", 32'(bus.busy), 0);
      bus.do_start = 1'b1; bus.ni = 4'd3; bus.k = 7'd0;
      settle();
      chk("do_k0_bad", 32'(bus.bad_cmd), 1);
      tick(); idle_in(); settle();
      chk("do_k0_busy", 32'(bus.busy), 0);

      // ---------------- basic do ni=3 k=4
      bus.do_start = 1'b1; bus.redo_start = 1'b1; bus.ni = 4'd3; bus.k = 7'd4;
      bus.step = 1'b1; bus.rom_dout = 16'hD000;
      settle();
      chk("do_ok_bad", 32'(bus.bad_cmd), 0);
      tick();
      bus.do_start = 1'b0; bus.redo_start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.rom_dout = body3[i];
         settle();
         chk("load_instr", 32'(bus.instr),   32'(body3[i]));
         chk("load_halt",  32'(bus.pc_halt), 0);
         chk("load_busy",  32'(bus.busy),    1);
         chk("load_done",  32'(bus.done),    0);
         tick();
      end
      bus.rom_dout = 16'hFFFF;
      halt_cnt = 0;
      for (int i = 0; i < 9; i++) begin
         bus.do_start = (i == 4);
         settle();
         if (bus.pc_halt) halt_cnt++;
         chk("rep_instr", 32'(bus.instr), 32'(body3[i % 3]));
         chk("rep_done",  32'(bus.done),  32'(i == 8));
         if (i == 4) chk("nested_do_bad", 32'(bus.bad_cmd), 1);
         tick();
      end
      bus.do_start = 1'b0;
      settle();
      chk("halt_steps",  32'(halt_cnt),    9);
      chk("rep_end_halt", 32'(bus.pc_halt), 0);
      chk("rep_end_busy", 32'(bus.busy),    0);
      chk("rep_end_instr", 32'(bus.instr),  32'hFFFF);

      // ---------------- redo k=2
      bus.redo_start = 1'b1; bus.k = 7'd2; bus.rom_dout = 16'h5555;
      settle();
      chk("redo_ok_bad", 32'(bus.bad_cmd), 0);
      tick();
      bus.redo_start = 1'b0; bus.rom_dout = 16'h7777;
      for (int i = 0; i < 6; i++) begin
         settle();
         chk("redo_instr", 32'(bus.instr),   32'(body3[i % 3]));
         chk("redo_halt",  32'(bus.pc_halt), 1);
         chk("redo_done",  32'(bus.done),    32'(i == 5));
         tick();
      end
      settle();
      chk("redo_end_busy", 32'(bus.busy), 0);

      // ---------------- do ni=2 k=1
      bus.do_start = 1'b1; bus.ni = 4'd2; bus.k = 7'd1; bus.rom_dout = 16'hD001;
      tick();
      bus.do_start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         bus.rom_dout = body2[i];
         settle();
         chk("k1_instr", 32'(bus.instr),   32'(body2[i]));
         chk("k1_halt",  32'(bus.pc_halt), 0);
         chk("k1_done",  32'(bus.done),    32'(i == 1));
         tick();
      end
      bus.rom_dout = 16'h3333;
      settle();
      chk("k1_end_busy", 32'(bus.busy),    0);
      chk("k1_end_halt", 32'(bus.pc_halt), 0);

      // ---------------- stall, cen low, reset mid-replay
      bus.redo_start = 1'b1; bus.k = 7'd3;
      tick();
      bus.redo_start = 1'b0;
      tick(); tick();                      // consume 1111, 2222 -> rd_ptr back to 0
      bus.step = 1'b0;
      for (int i = 0; i < 5; i++) begin
         settle();
         chk("stall_instr", 32'(bus.instr),   32'h1111);
         chk("stall_halt",  32'(bus.pc_halt), 1);
         chk("stall_done",  32'(bus.done),    0);
         tick();
      end
      bus.step = 1'b1; cen = 1'b0;
      for (int i = 0; i < 2; i++) begin
         settle();
         chk("cen0_instr", 32'(bus.instr), 32'h1111);
         chk("cen0_done",  32'(bus.done),  0);
         tick();
      end
      cen = 1'b1;
      settle();
      chk("resume_instr", 32'(bus.instr), 32'h1111);
      tick();
      settle();
      chk("resume_instr2", 32'(bus.instr), 32'h2222);
      chk("resume_done",   32'(bus.done),  0);
      rst = 1'b1;
      tick();
      rst = 1'b0; bus.step = 1'b0;
      settle();
      chk("midrst_halt", 32'(bus.pc_halt), 0);
      chk("midrst_busy", 32'(bus.busy),    0);
      bus.redo_start = 1'b1; bus.k = 7'd2;
      settle();
      chk("midrst_redo_bad", 32'(bus.bad_cmd), 1);
      tick(); idle_in();

`ifdef JTDSP16_LOOP_ABORT_EN
      // ---------------- abort during replay, then redo
      bus.do_start = 1'b1; bus.ni = 4'd2; bus.k = 7'd127; bus.step = 1'b1;
      tick();
      bus.do_start = 1'b0;
      bus.rom_dout = 16'h0A0A; tick();
      bus.rom_dout = 16'h0B0B; tick();
      bus.rom_dout = 16'hEEEE;
      for (int i = 0; i < 10; i++) tick();
      bus.abort = 1'b1;
      settle();
      chk("abort_instr", 32'(bus.instr), 32'h0A0A);
      chk("abort_done",  32'(bus.done),  1);
      tick();
      bus.abort = 1'b0;
      settle();
      chk("abort_halt", 32'(bus.pc_halt), 0);
      chk("abort_busy", 32'(bus.busy),    0);
      bus.redo_start = 1'b1; bus.k = 7'd2;
      settle();
      chk("abort_redo_bad", 32'(bus.bad_cmd), 0);
      tick();
      bus.redo_start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         settle();
         chk("abort_redo_instr", 32'(bus.instr), (i % 2 == 0) ? 32'h0A0A : 32'h0B0B);
         chk("abort_redo_done",  32'(bus.done),  32'(i == 3));
         tick();
      end
      idle_in();
`endif

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
`default_nettype wire
